// File: rtl/fejkon_csr_pkg.sv
// fejkon_csr_pkg: shared definitions for the fejkon CSR responder.
//   - register byte offsets of the CSR map
//   - bit positions of the request and completion word fields
//   - completion FIFO entry type and the helper that formats it into a 128-bit word
package fejkon_csr_pkg;

  // Register map (byte offsets)
  localparam logic [31:0] OFF_ID      = 32'h0000_0000;
  localparam logic [31:0] OFF_MAGIC   = 32'h0000_0004;
  localparam logic [31:0] OFF_CYCLES  = 32'h0000_0008;
  localparam logic [31:0] OFF_RDCNT   = 32'h0000_000c;
  localparam logic [31:0] OFF_WRCNT   = 32'h0000_0010;
  localparam logic [31:0] OFF_SCRATCH = 32'h0000_0080;

  localparam logic [31:0] UNMAPPED_VALUE = 32'hffff_ffff;

  // Request word fields
  localparam int REQ_WRITE_BIT = 0;
  localparam int REQ_TAG_LSB   = 1;
  localparam int REQ_TAG_MSB   = 24;
  localparam int REQ_WDATA_LSB = 1;
  localparam int REQ_WDATA_MSB = 32;
  localparam int REQ_ADDR_LSB  = 33;
  localparam int REQ_ADDR_MSB  = 62;

  // Completion word fields
  localparam int RESP_TAG_LSB   = 0;
  localparam int RESP_TAG_MSB   = 23;
  localparam int RESP_LADDR_LSB = 24;
  localparam int RESP_LADDR_MSB = 28;
  localparam int RESP_DATA_LSB  = 32;
  localparam int RESP_DATA_MSB  = 63;

  // One queued completion: requester ID/tag, byte address bits [6:2], read data
  typedef struct packed {
    logic [23:0] tag;
    logic [4:0]  lower_addr;
    logic [31:0] data;
  } resp_entry_t;

  // Format a queued entry as a completion word; every unnamed bit is zero
  function automatic logic [127:0] pack_completion(input resp_entry_t entry);
    logic [127:0] word;
    word = 128'd0;
    word[RESP_TAG_MSB:RESP_TAG_LSB]     = entry.tag;
    word[RESP_LADDR_MSB:RESP_LADDR_LSB] = entry.lower_addr;
    word[RESP_DATA_MSB:RESP_DATA_LSB]   = entry.data;
    return word;
  endfunction

endpackage

// File: rtl/fejkon_csr_if.sv
// fejkon_csr_if: memory-access request/completion bus of the CSR responder.
//   mem_access_req_data   [127:0] request word (master -> slave)
//   mem_access_req_valid          request present
//   mem_access_req_ready          slave can take a request this cycle
//   mem_access_resp_data  [127:0] completion word (slave -> master)
//   mem_access_resp_valid         completion present
//   mem_access_resp_ready         master takes the completion
interface fejkon_csr_if;

  logic [127:0] mem_access_req_data;
  logic         mem_access_req_valid;
  logic         mem_access_req_ready;
  logic [127:0] mem_access_resp_data;
  logic         mem_access_resp_valid;
  logic         mem_access_resp_ready;

  modport master (
    output mem_access_req_data,
    output mem_access_req_valid,
    input  mem_access_req_ready,
    input  mem_access_resp_data,
    input  mem_access_resp_valid,
    output mem_access_resp_ready
  );

  modport slave (
    input  mem_access_req_data,
    input  mem_access_req_valid,
    output mem_access_req_ready,
    output mem_access_resp_data,
    output mem_access_resp_valid,
    input  mem_access_resp_ready
  );

endinterface

// File: rtl/fejkon_csr_resp_fifo.sv
// fejkon_csr_resp_fifo: 2-entry completion FIFO.
//   clk        clock, rising edge
//   reset      synchronous active-low reset; empties the FIFO and zeroes both slots
//   push       store push_entry (ignored while full unless a pop frees a slot)
//   push_entry entry to store
//   pop        drop the head entry (ignored while empty)
//   head       current head entry, straight from a register
//   full       two entries held
//   empty      no entry held
// The FIFO is built as a two-slot shift register so the head is always slot 0
// and the completion output never passes through a read-pointer mux.
module fejkon_csr_resp_fifo
  import fejkon_csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output resp_entry_t head,
  output logic        full,
  output logic        empty
);

  resp_entry_t slot0_r;
  resp_entry_t slot1_r;
  logic        slot0_valid_r;
  logic        slot1_valid_r;

  resp_entry_t slot0_s;
  resp_entry_t slot1_s;
  logic        slot0_valid_s;
  logic        slot1_valid_s;
  logic        pop_s;
  logic        push_s;

  assign pop_s  = pop & slot0_valid_r;
  assign push_s = push & (~slot1_valid_r | pop_s);

  // Next slot contents and occupancy from the effective push/pop pair
  always_comb begin
    slot0_s       = slot0_r;
    slot1_s       = slot1_r;
    slot0_valid_s = slot0_valid_r;
    slot1_valid_s = slot1_valid_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (!slot0_valid_r) begin
          slot0_s       = push_entry;
          slot0_valid_s = 1'b1;
        end else begin
          slot1_s       = push_entry;
          slot1_valid_s = 1'b1;
        end
      end
      2'b01: begin
        slot0_s       = slot1_r;
        slot0_valid_s = slot1_valid_r;
        slot1_valid_s = 1'b0;
      end
      2'b11: begin
        // Occupancy stays the same; the new entry lands behind whatever remains
        if (slot1_valid_r) begin
          slot0_s = slot1_r;
          slot1_s = push_entry;
        end else begin
          slot0_s = push_entry;
        end
      end
      default: begin
        slot0_s = slot0_r;
      end
    endcase
  end

  // Slot registers; reset discards pending completions
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot0_r       <= '0;
      slot1_r       <= '0;
      slot0_valid_r <= 1'b0;
      slot1_valid_r <= 1'b0;
    end else begin
      slot0_r       <= slot0_s;
      slot1_r       <= slot1_s;
      slot0_valid_r <= slot0_valid_s;
      slot1_valid_r <= slot1_valid_s;
    end
  end

  assign head  = slot0_r;
  assign full  = slot1_valid_r;
  assign empty = ~slot0_valid_r;

endmodule

// File: rtl/fejkon_csr_responder.sv
// fejkon_csr_responder: CSR block answering memory-access requests.
//   clk         clock, rising edge
//   reset       synchronous active-low reset
//   mem_access  slave side of fejkon_csr_if (request in, completion out)
// Registers: 0x00 ID, 0x04 MAGIC, 0x08 CYCLES, 0x0C RDCNT, 0x10 WRCNT (RO,
// writes clear), 0x80 SCRATCH (RW). Reads produce one completion each through a
// 2-entry FIFO; writes produce none. Writes that clear a counter are not
// counted in WRCNT.
module fejkon_csr_responder
  import fejkon_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE      = 32'h02010de5,
  parameter logic [31:0] MAGIC_VALUE   = 32'hdeadbeef,
  parameter logic [31:0] SCRATCH_RESET = 32'hffffffff
) (
  input logic        clk,
  input logic        reset,
  fejkon_csr_if.slave mem_access
);

  logic        req_write_s;
  logic [31:0] req_addr_s;
  logic [23:0] req_tag_s;
  logic [31:0] req_wdata_s;
  logic        req_ready_s;
  logic        req_accept_s;
  logic        rd_accept_s;
  logic        wr_accept_s;
  logic [31:0] rd_data_s;
  logic        req_unused_s;

  logic [31:0] cycles_r;
  logic [31:0] rdcnt_r;
  logic [31:0] wrcnt_r;
  logic [31:0] scratch_r;
  logic        running_r;

  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        fifo_pop_s;
  resp_entry_t push_entry_s;
  resp_entry_t head_s;

  assign req_write_s  = mem_access.mem_access_req_data[REQ_WRITE_BIT];
  assign req_tag_s    = mem_access.mem_access_req_data[REQ_TAG_MSB:REQ_TAG_LSB];
  assign req_wdata_s  = mem_access.mem_access_req_data[REQ_WDATA_MSB:REQ_WDATA_LSB];
  assign req_addr_s   = {mem_access.mem_access_req_data[REQ_ADDR_MSB:REQ_ADDR_LSB], 2'b00};
  assign req_unused_s = ^mem_access.mem_access_req_data[127:REQ_ADDR_MSB+1];

  // Ready depends only on registered state: out of reset and a free FIFO slot
  assign req_ready_s  = running_r & ~fifo_full_s;
  assign req_accept_s = mem_access.mem_access_req_valid & req_ready_s;
  assign rd_accept_s  = req_accept_s & ~req_write_s;
  assign wr_accept_s  = req_accept_s & req_write_s;

  // Read decode using register values from before this edge
  always_comb begin
    rd_data_s = UNMAPPED_VALUE;
    case (req_addr_s)
      OFF_ID:      rd_data_s = ID_VALUE;
      OFF_MAGIC:   rd_data_s = MAGIC_VALUE;
      OFF_CYCLES:  rd_data_s = cycles_r;
      OFF_RDCNT:   rd_data_s = rdcnt_r;
      OFF_WRCNT:   rd_data_s = wrcnt_r;
      OFF_SCRATCH: rd_data_s = scratch_r;
      default:     rd_data_s = UNMAPPED_VALUE;
    endcase
  end

  // Marks the end of reset so ready rises one cycle after release
  always_ff @(posedge clk) begin
    if (!reset) begin
      running_r <= 1'b0;
    end else begin
      running_r <= 1'b1;
    end
  end

  // Free-running cycle counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycles_r <= 32'd0;
    end else begin
      cycles_r <= cycles_r + 32'd1;
    end
  end

  // Accepted-read counter, cleared by a write to its own offset
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdcnt_r <= 32'd0;
    end else if (wr_accept_s && (req_addr_s == OFF_RDCNT)) begin
      rdcnt_r <= 32'd0;
    end else if (rd_accept_s) begin
      rdcnt_r <= rdcnt_r + 32'd1;
    end else begin
      rdcnt_r <= rdcnt_r;
    end
  end

  // Accepted-write counter; counter-clearing writes are not counted
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrcnt_r <= 32'd0;
    end else if (wr_accept_s && (req_addr_s == OFF_WRCNT)) begin
      wrcnt_r <= 32'd0;
    end else if (wr_accept_s && (req_addr_s != OFF_RDCNT)) begin
      wrcnt_r <= wrcnt_r + 32'd1;
    end else begin
      wrcnt_r <= wrcnt_r;
    end
  end

  // Scratch register
  always_ff @(posedge clk) begin
    if (!reset) begin
      scratch_r <= SCRATCH_RESET;
    end else if (wr_accept_s && (req_addr_s == OFF_SCRATCH)) begin
      scratch_r <= req_wdata_s;
    end else begin
      scratch_r <= scratch_r;
    end
  end

  assign push_entry_s = '{tag: req_tag_s, lower_addr: req_addr_s[6:2], data: rd_data_s};
  assign fifo_pop_s   = ~fifo_empty_s & mem_access.mem_access_resp_ready;

  fejkon_csr_resp_fifo u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rd_accept_s),
    .push_entry (push_entry_s),
    .pop        (fifo_pop_s),
    .head       (head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  assign mem_access.mem_access_req_ready  = req_ready_s;
  assign mem_access.mem_access_resp_valid = ~fifo_empty_s;
  assign mem_access.mem_access_resp_data  = pack_completion(head_s);

endmodule

// File: tb/tb_fejkon_csr_responder.sv
// Self-checking bench for fejkon_csr_responder: directed scenarios plus a
// randomized run against a transaction-level model (register values, a
// completion queue and an occupancy-based ready prediction).
module tb_fejkon_csr_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fejkon_csr_if bus();

  fejkon_csr_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_access (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0]  m_scratch;
  logic [31:0]  m_rdcnt;
  logic [31:0]  m_wrcnt;
  logic [31:0]  m_cycles;
  bit           m_running;
  logic [127:0] m_q[$];
  bit           last_acc;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h02010de5;
      32'h04:  return 32'hdeadbeef;
      32'h08:  return m_cycles;
      32'h0c:  return m_rdcnt;
      32'h10:  return m_wrcnt;
      32'h80:  return m_scratch;
      default: return 32'hffffffff;
    endcase
  endfunction

  function automatic logic [127:0] mk_read(input logic [31:0] a, input logic [23:0] tag);
    logic [127:0] d;
    d = 128'd0;
    d[62:33] = a[31:2];
    d[24:1]  = tag;
    return d;
  endfunction

  function automatic logic [127:0] mk_write(input logic [31:0] a, input logic [31:0] data);
    logic [127:0] d;
    d = 128'd0;
    d[0]     = 1'b1;
    d[62:33] = a[31:2];
    d[32:1]  = data;
    return d;
  endfunction

  // One clock cycle: drive at the falling edge, advance the model across the
  // following rising edge, return 1 time unit after it.
  task automatic step(input bit rst_v, input bit v, input logic [127:0] d, input bit rr);
    logic [31:0] a;
    logic [31:0] rdata;
    bit acc;
    bit pop;
    @(negedge clk);
    reset = rst_v;
    bus.mem_access_req_valid  = v;
    bus.mem_access_req_data   = d;
    bus.mem_access_resp_ready = rr;
    a   = {d[62:33], 2'b00};
    acc = rst_v && v && m_running && (m_q.size() < 2);
    pop = rst_v && (m_q.size() > 0) && rr;
    if (!rst_v) begin
      m_q.delete();
      m_running = 0;
      m_cycles  = 32'd0;
      m_rdcnt   = 32'd0;
      m_wrcnt   = 32'd0;
      m_scratch = 32'hffffffff;
    end else begin
      rdata = model_read(a);
      if (pop) void'(m_q.pop_front());
      if (acc && !d[0]) begin
        m_q.push_back({64'd0, rdata, 3'b000, a[6:2], d[24:1]});
        m_rdcnt = m_rdcnt + 32'd1;
      end
      if (acc && d[0]) begin
        if (a == 32'h80) m_scratch = d[32:1];
        if (a == 32'h0c) m_rdcnt = 32'd0;
        else if (a == 32'h10) m_wrcnt = 32'd0;
        else m_wrcnt = m_wrcnt + 32'd1;
      end
      m_cycles  = m_cycles + 32'd1;
      m_running = 1;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 128'd0, 1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 128'd0, 1);
    n_checks++; if (bus.mem_access_req_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.mem_access_req_ready); else n_pass++;
    n_checks++; if (bus.mem_access_resp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.mem_access_resp_valid); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data !== 128'd0) $display("FAIL reset_data got=%h exp=0", bus.mem_access_resp_data); else n_pass++;
    step(1, 0, 128'd0, 1);
    n_checks++; if (bus.mem_access_req_ready !== 1'b1) $display("FAIL release_ready got=%b exp=1", bus.mem_access_req_ready); else n_pass++;
  endtask

  task automatic test_id_read();
    step(1, 1, mk_read(32'h00, 24'h123456), 1);
    n_checks++; if (bus.mem_access_resp_valid !== 1'b1) $display("FAIL id_valid got=%b exp=1", bus.mem_access_resp_valid); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'h02010de5) $display("FAIL id_data got=%h exp=02010de5", bus.mem_access_resp_data[63:32]); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data[23:0] !== 24'h123456) $display("FAIL id_tag got=%h exp=123456", bus.mem_access_resp_data[23:0]); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data[28:24] !== 5'h00) $display("FAIL id_laddr got=%h exp=00", bus.mem_access_resp_data[28:24]); else n_pass++;
    n_checks++; if ({bus.mem_access_resp_data[127:64], bus.mem_access_resp_data[31:29]} !== 67'd0) $display("FAIL id_zero_bits got=%h exp=0", bus.mem_access_resp_data[127:64]); else n_pass++;
    idle(1);
    n_checks++; if (bus.mem_access_resp_valid !== 1'b0) $display("FAIL id_popped got=%b exp=0", bus.mem_access_resp_valid); else n_pass++;
  endtask

  task automatic test_scratch();
    step(1, 1, mk_write(32'h80, 32'ha5a5a5a5), 1);
    n_checks++; if (bus.mem_access_resp_valid !== 1'b0) $display("FAIL write_no_completion got=%b exp=0", bus.mem_access_resp_valid); else n_pass++;
    step(1, 1, mk_read(32'h80, 24'h00beef), 1);
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'ha5a5a5a5) $display("FAIL scratch_data got=%h exp=a5a5a5a5", bus.mem_access_resp_data[63:32]); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data[28:24] !== 5'h00) $display("FAIL scratch_laddr got=%h exp=00", bus.mem_access_resp_data[28:24]); else n_pass++;
    idle(1);
  endtask

  task automatic test_unmapped();
    step(1, 1, mk_read(32'h44, 24'h000044), 1);
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'hffffffff) $display("FAIL unmapped_data got=%h exp=ffffffff", bus.mem_access_resp_data[63:32]); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data[28:24] !== 5'h11) $display("FAIL unmapped_laddr got=%h exp=11", bus.mem_access_resp_data[28:24]); else n_pass++;
    step(1, 1, mk_write(32'h00, 32'h0), 1);
    step(1, 1, mk_read(32'h00, 24'h000001), 1);
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'h02010de5) $display("FAIL ro_id_data got=%h exp=02010de5", bus.mem_access_resp_data[63:32]); else n_pass++;
    idle(1);
  endtask

  task automatic test_back_to_back();
    step(1, 1, mk_read(32'h04, 24'h000001), 0);
    step(1, 1, mk_read(32'h04, 24'h000002), 0);
    n_checks++; if (bus.mem_access_req_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", bus.mem_access_req_ready); else n_pass++;
    step(1, 1, mk_read(32'h04, 24'h000003), 0);
    n_checks++; if (bus.mem_access_resp_data[23:0] !== 24'h000001) $display("FAIL bp_hold_tag got=%h exp=000001", bus.mem_access_resp_data[23:0]); else n_pass++;
    n_checks++; if (bus.mem_access_req_ready !== 1'b0) $display("FAIL bp_stall_ready got=%b exp=0", bus.mem_access_req_ready); else n_pass++;
    step(1, 1, mk_read(32'h04, 24'h000003), 1);
    n_checks++; if (bus.mem_access_resp_data[23:0] !== 24'h000002) $display("FAIL bp_second_tag got=%h exp=000002", bus.mem_access_resp_data[23:0]); else n_pass++;
    n_checks++; if (bus.mem_access_req_ready !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", bus.mem_access_req_ready); else n_pass++;
    step(1, 1, mk_read(32'h04, 24'h000003), 1);
    n_checks++; if (bus.mem_access_resp_data[23:0] !== 24'h000003) $display("FAIL bp_third_tag got=%h exp=000003", bus.mem_access_resp_data[23:0]); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'hdeadbeef) $display("FAIL bp_magic got=%h exp=deadbeef", bus.mem_access_resp_data[63:32]); else n_pass++;
    idle(1);
    n_checks++; if (bus.mem_access_resp_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", bus.mem_access_resp_valid); else n_pass++;
  endtask

  task automatic test_counters();
    step(1, 1, mk_write(32'h0c, 32'h0), 1);
    step(1, 1, mk_write(32'h10, 32'h0), 1);
    for (int i = 0; i < 4; i++) step(1, 1, mk_read(32'h00, 24'(i)), 1);
    step(1, 1, mk_write(32'h44, 32'h1234), 1);
    step(1, 1, mk_read(32'h0c, 24'h00000c), 1);
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'd4) $display("FAIL rdcnt_value got=%0d exp=4", bus.mem_access_resp_data[63:32]); else n_pass++;
    step(1, 1, mk_read(32'h10, 24'h000010), 1);
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'd1) $display("FAIL wrcnt_value got=%0d exp=1", bus.mem_access_resp_data[63:32]); else n_pass++;
    step(1, 1, mk_write(32'h0c, 32'h0), 1);
    step(1, 1, mk_read(32'h0c, 24'h00000d), 1);
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'd0) $display("FAIL rdcnt_clear got=%0d exp=0", bus.mem_access_resp_data[63:32]); else n_pass++;
    step(1, 1, mk_read(32'h10, 24'h00000e), 1);
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'd1) $display("FAIL wrcnt_no_count_clear got=%0d exp=1", bus.mem_access_resp_data[63:32]); else n_pass++;
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] map_addr [8];
    logic [127:0] d;
    logic [31:0] a;
    int errs;
    map_addr[0] = 32'h00; map_addr[1] = 32'h04; map_addr[2] = 32'h08; map_addr[3] = 32'h0c;
    map_addr[4] = 32'h10; map_addr[5] = 32'h80; map_addr[6] = 32'h80; map_addr[7] = 32'h08;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        8:       a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        9:       a = {$urandom, 2'b00};
        default: a = map_addr[$urandom_range(0, 7)];
      endcase
      if ($urandom_range(0, 3) == 0) d = mk_write(a, $urandom);
      else begin
        d = mk_read(a, 24'($urandom));
        d[32:25] = 8'($urandom);
      end
      d[127:63] = {$urandom, $urandom, 1'($urandom)};
      step(1, $urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6);
      n_checks++;
      if (bus.mem_access_req_ready !== (m_q.size() < 2)) begin
        if (errs < 10) $display("FAIL rand_ready cycle=%0d got=%b exp=%b", i, bus.mem_access_req_ready, m_q.size() < 2);
        errs++;
      end else n_pass++;
      n_checks++;
      if (bus.mem_access_resp_valid !== (m_q.size() > 0)) begin
        if (errs < 10) $display("FAIL rand_valid cycle=%0d got=%b exp=%b", i, bus.mem_access_resp_valid, m_q.size() > 0);
        errs++;
      end else n_pass++;
      if (m_q.size() > 0) begin
        n_checks++;
        if (bus.mem_access_resp_data !== m_q[0]) begin
          if (errs < 10) $display("FAIL rand_data cycle=%0d got=%h exp=%h", i, bus.mem_access_resp_data, m_q[0]);
          errs++;
        end else n_pass++;
      end
    end
    idle(2);
    n_checks++; if (bus.mem_access_resp_valid !== 1'b0) $display("FAIL rand_drained got=%b exp=0", bus.mem_access_resp_valid); else n_pass++;
  endtask

  task automatic test_reset_flush();
    step(1, 1, mk_write(32'h80, 32'h13572468), 1);
    step(1, 1, mk_read(32'h00, 24'haaaaaa), 0);
    step(1, 1, mk_read(32'h80, 24'hbbbbbb), 0);
    n_checks++; if (bus.mem_access_req_ready !== 1'b0) $display("FAIL flush_full got=%b exp=0", bus.mem_access_req_ready); else n_pass++;
    step(0, 0, 128'd0, 0);
    n_checks++; if (bus.mem_access_resp_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", bus.mem_access_resp_valid); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data !== 128'd0) $display("FAIL flush_data got=%h exp=0", bus.mem_access_resp_data); else n_pass++;
    n_checks++; if (bus.mem_access_req_ready !== 1'b0) $display("FAIL flush_ready_low got=%b exp=0", bus.mem_access_req_ready); else n_pass++;
    step(1, 0, 128'd0, 1);
    n_checks++; if (bus.mem_access_resp_valid !== 1'b0) $display("FAIL flush_stale got=%b exp=0", bus.mem_access_resp_valid); else n_pass++;
    n_checks++; if (bus.mem_access_req_ready !== 1'b1) $display("FAIL flush_ready_high got=%b exp=1", bus.mem_access_req_ready); else n_pass++;
    step(1, 1, mk_read(32'h80, 24'h0000cc), 1);
    n_checks++; if (bus.mem_access_resp_data[63:32] !== 32'hffffffff) $display("FAIL flush_scratch got=%h exp=ffffffff", bus.mem_access_resp_data[63:32]); else n_pass++;
    n_checks++; if (bus.mem_access_resp_data[23:0] !== 24'h0000cc) $display("FAIL flush_tag got=%h exp=0000cc", bus.mem_access_resp_data[23:0]); else n_pass++;
    idle(1);
    n_checks++; if (bus.mem_access_resp_valid !== 1'b0) $display("FAIL flush_end got=%b exp=0", bus.mem_access_resp_valid); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    bus.mem_access_req_valid  = 1'b0;
    bus.mem_access_req_data   = 128'd0;
    bus.mem_access_resp_ready = 1'b1;
    m_running = 0;
    m_cycles  = 32'd0;
    m_rdcnt   = 32'd0;
    m_wrcnt   = 32'd0;
    m_scratch = 32'hffffffff;
    test_reset();
    test_id_read();
    test_scratch();
    test_unmapped();
    test_back_to_back();
    test_counters();
    test_random();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
